// File: rtl/tablero_nxn_maquina_if.sv
// Bus between the board input decoder / display driver and the N x N game
// controller.
//   erase            : synchronous new-game request (scores kept)
//   cuadro           : one-hot cell request, level held by the decoder
//   x, o             : cells owned by each player (index = row*N + col)
//   turnoX           : 1 = X to move
//   state            : controller state code
//   displayGanador*  : level flags, X or O has won the current game
//   displayEmpate    : level flag, current game is a draw
//   inc_*_score      : one-cycle pulse on a win
//   illegal_move     : one-cycle pulse on a rejected request
//   score_x, score_o : saturating games-won counters
interface tablero_nxn_maquina_if #(
  parameter int N       = 3,
  parameter int SCORE_W = 4
);
  logic                 erase;
  logic [N*N-1:0]       cuadro;
  logic [N*N-1:0]       x;
  logic [N*N-1:0]       o;
  logic                 turnoX;
  logic [3:0]           state;
  logic                 displayGanadorX;
  logic                 displayGanadorO;
  logic                 displayEmpate;
  logic                 inc_x_score;
  logic                 inc_o_score;
  logic                 illegal_move;
  logic [SCORE_W-1:0]   score_x;
  logic [SCORE_W-1:0]   score_o;

  modport master (
    output erase, cuadro,
    input  x, o, turnoX, state, displayGanadorX, displayGanadorO, displayEmpate,
           inc_x_score, inc_o_score, illegal_move, score_x, score_o
  );

  modport slave (
    input  erase, cuadro,
    output x, o, turnoX, state, displayGanadorX, displayGanadorO, displayEmpate,
           inc_x_score, inc_o_score, illegal_move, score_x, score_o
  );
endinterface

// File: rtl/tablero_nxn_maquina.sv
// N x N two-player X/O game controller. Accepts one-hot cell requests,
// enforces legal moves, alternates turns, scans the mover's lines one per
// cycle for a win and keeps saturating per-player scores.
//   clk_100MHz : system clock, all state on the rising edge
//   restart    : asynchronous active-high reset (board, scores, turn)
//   bus        : slave side of tablero_nxn_maquina_if (requests in, board,
//                flags, pulses and scores out)
//
// state   | meaning
// --------+--------------------------------------------------------------
// WAIT    | idle, accepting a single armed request on a free cell
// CHECK   | scanning line line_q of the player who just moved
// RELEASE | move done, waiting for the decoder to drop the request
// WIN_X   | X completed a line, holds until erase
// WIN_O   | O completed a line, holds until erase
// DRAW    | board full without a line, holds until erase
module tablero_nxn_maquina #(
  parameter int N       = 3,
  parameter int SCORE_W = 4,
  parameter int LINE_W  = 5
) (
  input  logic                    clk_100MHz,
  input  logic                    restart,
  tablero_nxn_maquina_if.slave    bus
);
  localparam int CELLS     = N * N;
  localparam int LAST_LINE = 2 * N + 1;
  localparam int MOVE_W    = $clog2(CELLS + 1);

  typedef enum logic [3:0] {
    WAIT    = 4'd0,
    CHECK   = 4'd1,
    RELEASE = 4'd2,
    WIN_X   = 4'd3,
    WIN_O   = 4'd4,
    DRAW    = 4'd5
  } state_t;

  state_t             state_q, state_d;
  logic [CELLS-1:0]   x_q, x_d, o_q, o_d;
  logic               turno_x_q, turno_x_d;
  logic               first_x_q, first_x_d;
  logic               armed_q, armed_d;
  logic [MOVE_W-1:0]  moves_q, moves_d;
  logic [LINE_W-1:0]  line_q, line_d;
  logic [SCORE_W-1:0] score_x_q, score_x_d, score_o_q, score_o_d;
  logic               inc_x_q, inc_x_d, inc_o_q, inc_o_d;
  logic               illegal_q, illegal_d;

  logic [CELLS-1:0]   line_mask;
  logic [CELLS-1:0]   mover;
  logic               line_hit;
  logic               one_hot;
  logic               free_cell;
  logic               idle_req;

  // Cell membership of the line under scan: rows, then columns, then the
  // main diagonal (row == col), then the anti-diagonal (row + col == N-1).
  always_comb begin
    line_mask = '0;
    for (int c = 0; c < CELLS; c++) begin
      if (int'(line_q) < N)
        line_mask[c] = (c / N == int'(line_q));
      else if (int'(line_q) < 2 * N)
        line_mask[c] = (c % N == int'(line_q) - N);
      else if (int'(line_q) == 2 * N)
        line_mask[c] = (c / N == c % N);
      else
        line_mask[c] = (c / N + c % N == N - 1);
    end
  end

  // turnoX only flips after the scan, so during CHECK it still names the mover.
  assign mover     = turno_x_q ? x_q : o_q;
  assign line_hit  = ((mover & line_mask) == line_mask);
  assign idle_req  = (bus.cuadro == '0);
  assign one_hot   = !idle_req && ((bus.cuadro & (bus.cuadro - CELLS'(1))) == '0);
  assign free_cell = ((bus.cuadro & (x_q | o_q)) == '0);

  always_ff @(posedge clk_100MHz or posedge restart) begin
    if (restart) begin
      state_q   <= WAIT;
      x_q       <= '0;
      o_q       <= '0;
      turno_x_q <= 1'b1;
      first_x_q <= 1'b1;
      armed_q   <= 1'b0;
      moves_q   <= '0;
      line_q    <= '0;
      score_x_q <= '0;
      score_o_q <= '0;
      inc_x_q   <= 1'b0;
      inc_o_q   <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      o_q       <= o_d;
      turno_x_q <= turno_x_d;
      first_x_q <= first_x_d;
      armed_q   <= armed_d;
      moves_q   <= moves_d;
      line_q    <= line_d;
      score_x_q <= score_x_d;
      score_o_q <= score_o_d;
      inc_x_q   <= inc_x_d;
      inc_o_q   <= inc_o_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    o_d       = o_q;
    turno_x_d = turno_x_q;
    first_x_d = first_x_q;
    armed_d   = armed_q;
    moves_d   = moves_q;
    line_d    = line_q;
    score_x_d = score_x_q;
    score_o_d = score_o_q;
    inc_x_d   = 1'b0;
    inc_o_d   = 1'b0;
    illegal_d = 1'b0;

    // A request is only consumed once; the decoder must go idle to re-arm.
    if (idle_req)
      armed_d = 1'b1;

    if (bus.erase) begin
      state_d   = WAIT;
      x_d       = '0;
      o_d       = '0;
      moves_d   = '0;
      line_d    = '0;
      first_x_d = ~first_x_q;
      turno_x_d = ~first_x_q;
      armed_d   = idle_req;
    end else begin
      case (state_q)
        WAIT: begin
          if (armed_q && !idle_req) begin
            armed_d = 1'b0;
            if (one_hot && free_cell) begin
              if (turno_x_q)
                x_d = x_q | bus.cuadro;
              else
                o_d = o_q | bus.cuadro;
              moves_d = moves_q + MOVE_W'(1);
              line_d  = '0;
              state_d = CHECK;
            end else begin
              illegal_d = 1'b1;
            end
          end
        end
        CHECK: begin
          if (line_hit) begin
            if (turno_x_q) begin
              state_d = WIN_X;
              inc_x_d = 1'b1;
              if (score_x_q != '1)
                score_x_d = score_x_q + SCORE_W'(1);
            end else begin
              state_d = WIN_O;
              inc_o_d = 1'b1;
              if (score_o_q != '1)
                score_o_d = score_o_q + SCORE_W'(1);
            end
          end else if (line_q == LINE_W'(LAST_LINE)) begin
            if (moves_q == MOVE_W'(CELLS)) begin
              state_d = DRAW;
            end else begin
              turno_x_d = ~turno_x_q;
              state_d   = RELEASE;
            end
          end else begin
            line_d = line_q + LINE_W'(1);
          end
        end
        RELEASE: begin
          if (idle_req)
            state_d = WAIT;
        end
        default: ;
      endcase
    end
  end

  assign bus.x               = x_q;
  assign bus.o               = o_q;
  assign bus.turnoX          = turno_x_q;
  assign bus.state           = state_q;
  assign bus.displayGanadorX = (state_q == WIN_X);
  assign bus.displayGanadorO = (state_q == WIN_O);
  assign bus.displayEmpate   = (state_q == DRAW);
  assign bus.inc_x_score     = inc_x_q;
  assign bus.inc_o_score     = inc_o_q;
  assign bus.illegal_move    = illegal_q;
  assign bus.score_x         = score_x_q;
  assign bus.score_o         = score_o_q;
endmodule

// File: tb/tb_tablero_nxn_maquina.sv
// Scoreboard bench for tablero_nxn_maquina: a 3x3 instance (4-bit scores)
// and a 4x4 instance (2-bit scores). Stimulus pushes expected events; one
// monitor per instance pops and compares whenever the DUT shows an event
// (illegal/inc pulse, entry to DRAW, or a bench probe strobe).
module tb_tablero_nxn_maquina;
  typedef struct packed {
    logic [2:0]  kind;   // 1 illegal, 2 inc_x, 3 inc_o, 4 draw entry, 5 probe
    logic [63:0] x;
    logic [63:0] o;
    logic        turn;
    logic [3:0]  st;
    logic [2:0]  flg;    // {displayGanadorX, displayGanadorO, displayEmpate}
    logic [7:0]  sx;
    logic [7:0]  so;
    logic [5:0]  chk;    // CHECK cycles of the latest scan, 63 = don't care
  } ev_t;

  localparam logic [5:0] DC = 6'h3f;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst3, rst4, probe3, probe4;

  tablero_nxn_maquina_if #(.N(3), .SCORE_W(4)) bus3 ();
  tablero_nxn_maquina_if #(.N(4), .SCORE_W(2)) bus4 ();

  tablero_nxn_maquina #(.N(3), .SCORE_W(4), .LINE_W(5)) dut3 (
    .clk_100MHz (clk),
    .restart    (rst3),
    .bus        (bus3.slave)
  );

  tablero_nxn_maquina #(.N(4), .SCORE_W(2), .LINE_W(5)) dut4 (
    .clk_100MHz (clk),
    .restart    (rst4),
    .bus        (bus4.slave)
  );

  ev_t   q3[$], q4[$];
  string n3[$], n4[$];
  int    checks = 0;
  int    failures = 0;

  logic [3:0] prev3 = 4'd0, prev4 = 4'd0;
  logic [5:0] run3 = 6'd0, run4 = 6'd0, last3 = 6'd0, last4 = 6'd0;

  task automatic expect_ev(input int which, input string nm, input logic [2:0] k,
                           input logic [63:0] x, input logic [63:0] o, input logic t,
                           input logic [3:0] st, input logic [2:0] f,
                           input logic [7:0] sx, input logic [7:0] so, input logic [5:0] chk);
    ev_t e;
    e.kind = k; e.x = x; e.o = o; e.turn = t; e.st = st; e.flg = f;
    e.sx = sx; e.so = so; e.chk = chk;
    if (which == 3) begin q3.push_back(e); n3.push_back(nm); end
    else begin q4.push_back(e); n4.push_back(nm); end
  endtask

  task automatic check_event(input int which, input ev_t a);
    ev_t   e;
    string nm;
    checks++;
    if ((which == 3 && q3.size() == 0) || (which == 4 && q4.size() == 0)) begin
      failures++;
      $display("FAIL unexpected_event_dut%0d: got kind=%0d st=%0d, expected no event", which, a.kind, a.st);
    end else begin
      if (which == 3) begin e = q3.pop_front(); nm = n3.pop_front(); end
      else begin e = q4.pop_front(); nm = n4.pop_front(); end
      if (e.kind != a.kind || e.x != a.x || e.o != a.o || e.turn != a.turn || e.st != a.st ||
          e.flg != a.flg || e.sx != a.sx || e.so != a.so || (e.chk != DC && e.chk != a.chk)) begin
        failures++;
        $display("FAIL %s: got kind=%0d x=%h o=%h turn=%0d st=%0d flg=%b sx=%0d so=%0d chk=%0d; expected kind=%0d x=%h o=%h turn=%0d st=%0d flg=%b sx=%0d so=%0d chk=%0d",
                 nm, a.kind, a.x[15:0], a.o[15:0], a.turn, a.st, a.flg, a.sx, a.so, a.chk,
                 e.kind, e.x[15:0], e.o[15:0], e.turn, e.st, e.flg, e.sx, e.so, e.chk);
      end
    end
  endtask

  initial begin : mon3
    ev_t  a;
    logic hit;
    forever begin
      @(negedge clk);
      if (bus3.state == 4'd1) run3 = (prev3 == 4'd1) ? run3 + 6'd1 : 6'd1;
      else if (prev3 == 4'd1) last3 = run3;
      a = '0;
      a.x = 64'(bus3.x); a.o = 64'(bus3.o); a.turn = bus3.turnoX; a.st = bus3.state;
      a.flg = {bus3.displayGanadorX, bus3.displayGanadorO, bus3.displayEmpate};
      a.sx = 8'(bus3.score_x); a.so = 8'(bus3.score_o); a.chk = last3;
      hit = 1'b1;
      if (bus3.illegal_move) a.kind = 3'd1;
      else if (bus3.inc_x_score) a.kind = 3'd2;
      else if (bus3.inc_o_score) a.kind = 3'd3;
      else if (bus3.state == 4'd5 && prev3 != 4'd5) a.kind = 3'd4;
      else if (probe3) a.kind = 3'd5;
      else hit = 1'b0;
      prev3 = bus3.state;
      if (hit) check_event(3, a);
    end
  end

  initial begin : mon4
    ev_t  a;
    logic hit;
    forever begin
      @(negedge clk);
      if (bus4.state == 4'd1) run4 = (prev4 == 4'd1) ? run4 + 6'd1 : 6'd1;
      else if (prev4 == 4'd1) last4 = run4;
      a = '0;
      a.x = 64'(bus4.x); a.o = 64'(bus4.o); a.turn = bus4.turnoX; a.st = bus4.state;
      a.flg = {bus4.displayGanadorX, bus4.displayGanadorO, bus4.displayEmpate};
      a.sx = 8'(bus4.score_x); a.so = 8'(bus4.score_o); a.chk = last4;
      hit = 1'b1;
      if (bus4.illegal_move) a.kind = 3'd1;
      else if (bus4.inc_x_score) a.kind = 3'd2;
      else if (bus4.inc_o_score) a.kind = 3'd3;
      else if (bus4.state == 4'd5 && prev4 != 4'd5) a.kind = 3'd4;
      else if (probe4) a.kind = 3'd5;
      else hit = 1'b0;
      prev4 = bus4.state;
      if (hit) check_event(4, a);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic hold3(input logic [8:0] m, input int h, input int r);
    bus3.cuadro = m; tick(h); bus3.cuadro = '0; tick(r);
  endtask

  task automatic hold4(input logic [15:0] m, input int h, input int r);
    bus4.cuadro = m; tick(h); bus4.cuadro = '0; tick(r);
  endtask

  task automatic cell3(input int c);
    logic [8:0] m;
    m = '0; m[c[3:0]] = 1'b1;
    hold3(m, 20, 10);
  endtask

  task automatic cell4(input int c);
    logic [15:0] m;
    m = '0; m[c[3:0]] = 1'b1;
    hold4(m, 20, 10);
  endtask

  task automatic erase3();
    bus3.erase = 1'b1; tick(1); bus3.erase = 1'b0; tick(1);
  endtask

  task automatic erase4();
    bus4.erase = 1'b1; tick(1); bus4.erase = 1'b0; tick(1);
  endtask

  task automatic probe_3();
    probe3 = 1'b1; tick(1); probe3 = 1'b0; tick(1);
  endtask

  task automatic probe_4();
    probe4 = 1'b1; tick(1); probe4 = 1'b0; tick(1);
  endtask

  int seq[$];

  initial begin
    rst3 = 1'b1; rst4 = 1'b1; probe3 = 1'b0; probe4 = 1'b0;
    bus3.erase = 1'b0; bus3.cuadro = '0;
    bus4.erase = 1'b0; bus4.cuadro = '0;
    tick(3);
    rst3 = 1'b0; rst4 = 1'b0;
    tick(2);

    // ---------------- 3x3 instance ----------------
    expect_ev(3, "reset3", 3'd5, 64'h0, 64'h0, 1'b1, 4'd0, 3'b000, 8'd0, 8'd0, DC);
    probe_3();

    expect_ev(3, "x_row1_win", 3'd2, 64'h038, 64'h180, 1'b1, 4'd3, 3'b100, 8'd1, 8'd0, 6'd2);
    seq = '{3, 7, 4, 8, 5};
    foreach (seq[i]) cell3(seq[i]);
    hold3(9'h001, 10, 5);
    expect_ev(3, "win_hold", 3'd5, 64'h038, 64'h180, 1'b1, 4'd3, 3'b100, 8'd1, 8'd0, DC);
    probe_3();

    erase3();
    expect_ev(3, "erase_turn0", 3'd5, 64'h0, 64'h0, 1'b0, 4'd0, 3'b000, 8'd1, 8'd0, DC);
    probe_3();
    erase3();
    expect_ev(3, "erase_turn1", 3'd5, 64'h0, 64'h0, 1'b1, 4'd0, 3'b000, 8'd1, 8'd0, DC);
    probe_3();

    cell3(0);
    expect_ev(3, "illegal_occupied", 3'd1, 64'h001, 64'h0, 1'b0, 4'd0, 3'b000, 8'd1, 8'd0, DC);
    hold3(9'h001, 20, 10);
    expect_ev(3, "illegal_multi", 3'd1, 64'h001, 64'h0, 1'b0, 4'd0, 3'b000, 8'd1, 8'd0, DC);
    hold3(9'h003, 20, 10);

    erase3();
    expect_ev(3, "erase_turn0_b", 3'd5, 64'h0, 64'h0, 1'b0, 4'd0, 3'b000, 8'd1, 8'd0, DC);
    probe_3();
    erase3();
    expect_ev(3, "draw", 3'd4, 64'h18D, 64'h072, 1'b1, 4'd5, 3'b001, 8'd1, 8'd0, 6'd8);
    seq = '{0, 1, 2, 4, 3, 5, 7, 6, 8};
    foreach (seq[i]) cell3(seq[i]);
    hold3(9'h001, 10, 5);
    expect_ev(3, "draw_hold", 3'd5, 64'h18D, 64'h072, 1'b1, 4'd5, 3'b001, 8'd1, 8'd0, DC);
    probe_3();

    erase3();
    bus3.cuadro = 9'h010;
    @(posedge clk);
    #2;
    rst3 = 1'b1; probe3 = 1'b1;
    expect_ev(3, "restart_midcheck", 3'd5, 64'h0, 64'h0, 1'b1, 4'd0, 3'b000, 8'd0, 8'd0, DC);
    #6;
    probe3 = 1'b0; rst3 = 1'b0; bus3.cuadro = '0;
    tick(3);

    expect_ev(3, "o_row1_win", 3'd3, 64'h103, 64'h038, 1'b0, 4'd4, 3'b010, 8'd0, 8'd1, 6'd2);
    seq = '{0, 3, 1, 4, 8, 5};
    foreach (seq[i]) cell3(seq[i]);

    // ---------------- 4x4 instance, 2-bit scores ----------------
    expect_ev(4, "reset4", 3'd5, 64'h0, 64'h0, 1'b1, 4'd0, 3'b000, 8'd0, 8'd0, DC);
    probe_4();

    expect_ev(4, "x4_win_a", 3'd2, 64'h000F, 64'h0070, 1'b1, 4'd3, 3'b100, 8'd1, 8'd0, 6'd1);
    seq = '{0, 4, 1, 5, 2, 6, 3};
    foreach (seq[i]) cell4(seq[i]);
    erase4();
    expect_ev(4, "x4_erase_turn0", 3'd5, 64'h0, 64'h0, 1'b0, 4'd0, 3'b000, 8'd1, 8'd0, DC);
    probe_4();

    expect_ev(4, "x4_win_b", 3'd2, 64'h000F, 64'h0170, 1'b1, 4'd3, 3'b100, 8'd2, 8'd0, 6'd1);
    seq = '{4, 0, 5, 1, 6, 2, 8, 3};
    foreach (seq[i]) cell4(seq[i]);
    erase4();
    expect_ev(4, "x4_erase_turn1", 3'd5, 64'h0, 64'h0, 1'b1, 4'd0, 3'b000, 8'd2, 8'd0, DC);
    probe_4();

    expect_ev(4, "x4_win_c", 3'd2, 64'h000F, 64'h0070, 1'b1, 4'd3, 3'b100, 8'd3, 8'd0, 6'd1);
    seq = '{0, 4, 1, 5, 2, 6, 3};
    foreach (seq[i]) cell4(seq[i]);
    erase4();

    expect_ev(4, "x4_win_saturated", 3'd2, 64'h000F, 64'h0170, 1'b1, 4'd3, 3'b100, 8'd3, 8'd0, 6'd1);
    seq = '{4, 0, 5, 1, 6, 2, 8, 3};
    foreach (seq[i]) cell4(seq[i]);
    erase4();

    expect_ev(4, "x4_antidiag", 3'd2, 64'h1248, 64'h0007, 1'b1, 4'd3, 3'b100, 8'd3, 8'd0, 6'd10);
    seq = '{3, 0, 6, 1, 9, 2, 12};
    foreach (seq[i]) cell4(seq[i]);

    tick(10);
    checks++;
    if (q3.size() != 0) begin
      failures++;
      $display("FAIL pending_dut3: got %0d unseen events, expected 0", q3.size());
    end
    checks++;
    if (q4.size() != 0) begin
      failures++;
      $display("FAIL pending_dut4: got %0d unseen events, expected 0", q4.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
